load_store_address_stage: RTL and testbench

Address-generation and transfer-sequencing stage of the load/store pipe, directly upstream of `load_store_memory_stage`. It accepts one decoded load/store instruction at a time (LDR/STR, byte and halfword variants, LDM/STM, SWP), computes effective and writeback addresses, and splits multi-transfer instructions into single-beat transfers. Each beat is emitted as the memory stage's control-word fields, one beat per cycle.

---
 rtl/load_store_address_stage_pkg.sv | 57 +++++
 rtl/load_store_address_stage_reg_list_sequencer.sv | 24 ++
 rtl/load_store_address_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_load_store_address_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_address_stage_pkg.sv
// Shared encodings for the load/store address stage and its memory-stage control word.
package load_store_address_stage_define;

  localparam int REG_ADDR_W = 4;
  localparam int OFFSET_W   = 12;
  localparam int LIST_W     = 16;
  localparam int LOAD_MUX_W = 3;
  localparam int STR_MUX_W  = 2;
  localparam int WEN_W      = 4;

  typedef enum logic [2:0] {
    OP_LDR = 3'd0,
    OP_STR = 3'd1,
    OP_LDM = 3'd2,
    OP_STM = 3'd3,
    OP_SWP = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    SZ_WORD  = 3'd0,
    SZ_UBYTE = 3'd1,
    SZ_SBYTE = 3'd2,
    SZ_UHALF = 3'd3,
    SZ_SHALF = 3'd4
  } size_e;

  typedef enum logic [1:0] {
    STR_WORD = 2'd0,
    STR_BYTE = 2'd1,
    STR_HALF = 2'd2
  } str_mux_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MULTI  = 2'd1,
    S_SWP_ST = 2'd2
  } state_e;

  // Byte lanes written by a single store of the given size at address offset lo.
  function automatic logic [WEN_W-1:0] store_wen(input logic [2:0] size, input logic [1:0] lo);
    case (size_e'(size))
      SZ_UBYTE, SZ_SBYTE: store_wen = 4'b0001 << lo;
      SZ_UHALF, SZ_SHALF: store_wen = lo[1] ? 4'b1100 : 4'b0011;
      default:            store_wen = 4'b1111;
    endcase
  endfunction

  // Store data replication format for a single store of the given size.
  function automatic logic [STR_MUX_W-1:0] store_mux(input logic [2:0] size);
    case (size_e'(size))
      SZ_UBYTE, SZ_SBYTE: store_mux = STR_BYTE;
      SZ_UHALF, SZ_SHALF: store_mux = STR_HALF;
      default:            store_mux = STR_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_address_stage_reg_list_sequencer.sv
// Register-list helpers: popcount, lowest set index and clear-lowest over 16 bits.
module reg_list_sequencer (
  input  logic [15:0] list,
  output logic [4:0]  count,
  output logic [3:0]  lowest,
  output logic        any,
  output logic [15:0] cleared
);

  // Population count and priority encode of the lowest set bit.
  always_comb begin
    count  = '0;
    lowest = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      count = count + 5'(list[4'(i)]);
    end
    for (int unsigned i = 16; i > 0; i--) begin
      if (list[4'(i - 1)]) lowest = 4'(i - 1);
    end
    any     = |list;
    cleared = list & (list - 16'd1);
  end

endmodule

// File: rtl/load_store_address_stage.sv
// Address generation and beat sequencing for LDR/STR, LDM/STM and SWP.
module load_store_address_stage
  import load_store_address_stage_define::*;
#(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              issue_valid_in,
  output logic              issue_ready_out,
  input  logic [TAG_W-1:0]  instr_tag_in,
  input  logic [3:0]        rd_addr_in,
  input  logic [3:0]        rn_addr_in,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic [DATA_W-1:0] rn_data_in,
  input  logic [11:0]       offset_in,
  input  logic [2:0]        op_in,
  input  logic [2:0]        size_in,
  input  logic              p_in,
  input  logic              u_in,
  input  logic              w_in,
  input  logic [15:0]       reg_list_in,
  input  logic              stall_in,
  output logic [TAG_W-1:0]  instr_tag_out,
  output logic [3:0]        rd_addr_out,
  output logic [3:0]        rn_addr_out,
  output logic [DATA_W-1:0] store_rd_data_out,
  output logic [DATA_W-1:0] rn_data_out,
  output logic [DATA_W-1:0] mem_addr_out,
  output logic              swp_ctrl_out,
  output logic [2:0]        ctrl_load_mux_out,
  output logic [1:0]        ctrl_str_mux_out,
  output logic [3:0]        w_en_out,
  output logic              instr_confirmed_out,
  output logic              load_store_multiple_en_out,
  output logic              memory_stage_start_out
);

  state_e state_q, state_d;
  logic        ready_q;
  logic [15:0] list_q, list_d;

  logic [TAG_W-1:0]  tag_d;
  logic [3:0]        rd_addr_d, rn_addr_d, wen_d;
  logic [DATA_W-1:0] sd_d, rn_data_d, addr_d;
  logic              swp_d, conf_d, lsm_d, start_d;
  logic [2:0]        lmux_d;
  logic [1:0]        smux_d;

  logic [15:0] seq_list, seq_cleared;
  logic [4:0]  seq_count;
  logic [3:0]  seq_lowest;
  logic        seq_any;

  logic [DATA_W-1:0] ea, single_addr, n4, multi_wb, multi_start;
  logic              accept;

  // While sequencing, the sequencer walks the remaining list; otherwise it looks at the incoming one.
  assign seq_list = (state_q == S_MULTI) ? list_q : reg_list_in;

  reg_list_sequencer u_seq (
    .list    (seq_list),
    .count   (seq_count),
    .lowest  (seq_lowest),
    .any     (seq_any),
    .cleared (seq_cleared)
  );

  assign issue_ready_out = ready_q && (state_q == S_IDLE) && !stall_in;
  assign accept          = issue_valid_in && issue_ready_out;

  // Address arithmetic for single and multiple transfers.
  always_comb begin
    ea          = u_in ? rn_data_in + DATA_W'(offset_in) : rn_data_in - DATA_W'(offset_in);
    single_addr = p_in ? ea : rn_data_in;
    n4          = DATA_W'({seq_count, 2'b00});
    multi_wb    = u_in ? rn_data_in + n4 : rn_data_in - n4;
    case ({p_in, u_in})
      2'b01:   multi_start = rn_data_in;
      2'b11:   multi_start = rn_data_in + DATA_W'(4);
      2'b00:   multi_start = rn_data_in - n4 + DATA_W'(4);
      default: multi_start = rn_data_in - n4;
    endcase
  end

  // Next-state and next-beat selection; unchanged beat fields hold their previous value.
  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    tag_d     = instr_tag_out;
    rd_addr_d = rd_addr_out;
    rn_addr_d = rn_addr_out;
    sd_d      = store_rd_data_out;
    rn_data_d = rn_data_out;
    addr_d    = mem_addr_out;
    swp_d     = swp_ctrl_out;
    lmux_d    = ctrl_load_mux_out;
    smux_d    = ctrl_str_mux_out;
    wen_d     = w_en_out;
    conf_d    = instr_confirmed_out;
    lsm_d     = load_store_multiple_en_out;
    start_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tag_d     = instr_tag_in;
          rd_addr_d = rd_addr_in;
          rn_addr_d = rn_addr_in;
          sd_d      = rd_data_in;
          case (op_e'(op_in))
            OP_LDR, OP_STR: begin
              addr_d    = single_addr;
              rn_data_d = w_in ? ea : rn_data_in;
              swp_d     = 1'b0;
              lsm_d     = 1'b0;
              conf_d    = 1'b1;
              start_d   = 1'b1;
              if (op_in == OP_STR) begin
                lmux_d = SZ_WORD;
                smux_d = store_mux(size_in);
                wen_d  = store_wen(size_in, single_addr[1:0]);
              end else begin
                lmux_d = size_in;
                smux_d = STR_WORD;
                wen_d  = '0;
              end
            end
            OP_LDM, OP_STM: begin
              // An empty list is consumed silently with no beat.
              if (seq_any) begin
                addr_d    = multi_start;
                rd_addr_d = seq_lowest;
                rn_data_d = w_in ? multi_wb : rn_data_in;
                swp_d     = 1'b0;
                lsm_d     = 1'b1;
                lmux_d    = SZ_WORD;
                smux_d    = STR_WORD;
                wen_d     = (op_in == OP_STM) ? '1 : '0;
                conf_d    = (seq_cleared == '0);
                start_d   = 1'b1;
                list_d    = seq_cleared;
                state_d   = (seq_cleared == '0) ? S_IDLE : S_MULTI;
              end
            end
            OP_SWP: begin
              addr_d    = rn_data_in;
              rn_data_d = rn_data_in;
              swp_d     = 1'b1;
              lsm_d     = 1'b0;
              lmux_d    = SZ_WORD;
              smux_d    = STR_WORD;
              wen_d     = '0;
              conf_d    = 1'b0;
              start_d   = 1'b1;
              state_d   = S_SWP_ST;
            end
            default: ;
          endcase
        end
      end
      S_MULTI: begin
        addr_d    = mem_addr_out + DATA_W'(4);
        rd_addr_d = seq_lowest;
        conf_d    = (seq_cleared == '0);
        start_d   = 1'b1;
        list_d    = seq_cleared;
        state_d   = (seq_cleared == '0) ? S_IDLE : S_MULTI;
      end
      S_SWP_ST: begin
        wen_d   = '1;
        conf_d  = 1'b1;
        start_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered beat outputs; a stall freezes everything.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q                    <= S_IDLE;
      ready_q                    <= 1'b0;
      list_q                     <= '0;
      instr_tag_out              <= '0;
      rd_addr_out                <= '0;
      rn_addr_out                <= '0;
      store_rd_data_out          <= '0;
      rn_data_out                <= '0;
      mem_addr_out               <= '0;
      swp_ctrl_out               <= 1'b0;
      ctrl_load_mux_out          <= '0;
      ctrl_str_mux_out           <= '0;
      w_en_out                   <= '0;
      instr_confirmed_out        <= 1'b0;
      load_store_multiple_en_out <= 1'b0;
      memory_stage_start_out     <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (!stall_in) begin
        state_q                    <= state_d;
        list_q                     <= list_d;
        instr_tag_out              <= tag_d;
        rd_addr_out                <= rd_addr_d;
        rn_addr_out                <= rn_addr_d;
        store_rd_data_out          <= sd_d;
        rn_data_out                <= rn_data_d;
        mem_addr_out               <= addr_d;
        swp_ctrl_out               <= swp_d;
        ctrl_load_mux_out          <= lmux_d;
        ctrl_str_mux_out           <= smux_d;
        w_en_out                   <= wen_d;
        instr_confirmed_out        <= conf_d;
        load_store_multiple_en_out <= lsm_d;
        memory_stage_start_out     <= start_d;
      end
    end
  end

endmodule

// File: tb/tb_load_store_address_stage.sv
// Bench for load_store_address_stage: per-instruction beat lists from the address rules, checked every cycle.
module tb_load_store_address_stage;

  typedef struct packed {
    logic [3:0]  tag;
    logic [3:0]  rd;
    logic [3:0]  rn_a;
    logic [31:0] rd_data;
    logic [31:0] rn_data;
    logic [11:0] off;
    logic [2:0]  op;
    logic [2:0]  size;
    logic        p;
    logic        u;
    logic        w;
    logic [15:0] list;
  } instr_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [3:0]  rd;
    logic [3:0]  rn_a;
    logic [31:0] sd;
    logic        chk_sd;
    logic [31:0] rn_data;
    logic [31:0] addr;
    logic        swp;
    logic [2:0]  lmux;
    logic [1:0]  smux;
    logic [3:0]  wen;
    logic        conf;
    logic        lsm;
  } beat_t;

  logic clk = 1'b0;
  logic reset_in = 1'b0;
  logic issue_valid_in = 1'b0;
  logic stall_in = 1'b0;
  instr_t ins = '0;
  bit rand_stall = 1'b0;

  logic        issue_ready_out;
  logic [3:0]  instr_tag_out, rd_addr_out, rn_addr_out, w_en_out;
  logic [31:0] store_rd_data_out, rn_data_out, mem_addr_out;
  logic        swp_ctrl_out, instr_confirmed_out, load_store_multiple_en_out, memory_stage_start_out;
  logic [2:0]  ctrl_load_mux_out;
  logic [1:0]  ctrl_str_mux_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_address_stage #(.TAG_W(4), .DATA_W(32)) dut (
    .clk_in                     (clk),
    .reset_in                   (reset_in),
    .issue_valid_in             (issue_valid_in),
    .issue_ready_out            (issue_ready_out),
    .instr_tag_in               (ins.tag),
    .rd_addr_in                 (ins.rd),
    .rn_addr_in                 (ins.rn_a),
    .rd_data_in                 (ins.rd_data),
    .rn_data_in                 (ins.rn_data),
    .offset_in                  (ins.off),
    .op_in                      (ins.op),
    .size_in                    (ins.size),
    .p_in                       (ins.p),
    .u_in                       (ins.u),
    .w_in                       (ins.w),
    .reg_list_in                (ins.list),
    .stall_in                   (stall_in),
    .instr_tag_out              (instr_tag_out),
    .rd_addr_out                (rd_addr_out),
    .rn_addr_out                (rn_addr_out),
    .store_rd_data_out          (store_rd_data_out),
    .rn_data_out                (rn_data_out),
    .mem_addr_out               (mem_addr_out),
    .swp_ctrl_out               (swp_ctrl_out),
    .ctrl_load_mux_out          (ctrl_load_mux_out),
    .ctrl_str_mux_out           (ctrl_str_mux_out),
    .w_en_out                   (w_en_out),
    .instr_confirmed_out        (instr_confirmed_out),
    .load_store_multiple_en_out (load_store_multiple_en_out),
    .memory_stage_start_out     (memory_stage_start_out)
  );

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic int nbeats(input instr_t i);
    case (i.op)
      3'd0, 3'd1: return 1;
      3'd2, 3'd3: return $countones(i.list);
      3'd4:       return 2;
      default:    return 0;
    endcase
  endfunction

  // k-th beat of instruction i, derived directly from the addressing rules.
  function automatic beat_t nth_beat(input instr_t i, input int k);
    beat_t b;
    logic [31:0] ea, n4, lo;
    int n, seen;
    b = '0;
    b.tag = i.tag; b.rd = i.rd; b.rn_a = i.rn_a; b.sd = i.rd_data;
    n  = $countones(i.list);
    n4 = 32'(4 * n);
    case (i.op)
      3'd0, 3'd1: begin
        ea = i.u ? i.rn_data + 32'(i.off) : i.rn_data - 32'(i.off);
        b.addr    = i.p ? ea : i.rn_data;
        b.rn_data = i.w ? ea : i.rn_data;
        b.conf    = 1'b1;
        if (i.op == 3'd1) begin
          b.chk_sd = 1'b1;
          if (i.size == 3'd1 || i.size == 3'd2) begin
            b.smux = 2'd1; b.wen = 4'(1 << b.addr[1:0]);
          end else if (i.size == 3'd3 || i.size == 3'd4) begin
            b.smux = 2'd2; b.wen = b.addr[1] ? 4'b1100 : 4'b0011;
          end else begin
            b.smux = 2'd0; b.wen = 4'b1111;
          end
        end else begin
          b.lmux = i.size;
        end
      end
      3'd2, 3'd3: begin
        if (i.u) lo = i.p ? i.rn_data + 32'd4 : i.rn_data;
        else     lo = i.p ? i.rn_data - n4 : i.rn_data - n4 + 32'd4;
        seen = 0;
        for (int r = 0; r < 16; r++) begin
          if (i.list[r]) begin
            if (seen == k) b.rd = 4'(r);
            seen++;
          end
        end
        b.addr    = lo + 32'(4 * k);
        b.rn_data = i.w ? (i.u ? i.rn_data + n4 : i.rn_data - n4) : i.rn_data;
        b.lsm     = 1'b1;
        b.conf    = (k == n - 1);
        if (i.op == 3'd3) begin b.wen = 4'b1111; b.chk_sd = 1'b1; end
      end
      default: begin
        b.addr = i.rn_data; b.rn_data = i.rn_data; b.swp = 1'b1;
        if (k == 1) begin b.wen = 4'b1111; b.conf = 1'b1; b.chk_sd = 1'b1; end
      end
    endcase
    return b;
  endfunction

  // Compare process: checks last edge's outputs, then advances the model with the inputs for the next edge.
  initial begin : compare
    beat_t q[$];
    beat_t cur;
    bit cur_v, in_rst, rel, exp_ready;
    cur = '0; cur_v = 1'b0; in_rst = 1'b1; rel = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (in_rst) begin
        chk("rst_start", 32'(memory_stage_start_out), 32'd0);
        chk("rst_addr", mem_addr_out, 32'd0);
        chk("rst_rn_data", rn_data_out, 32'd0);
        chk("rst_sd", store_rd_data_out, 32'd0);
        chk("rst_misc", {15'd0, instr_tag_out, rd_addr_out, rn_addr_out, w_en_out, swp_ctrl_out,
                         instr_confirmed_out, load_store_multiple_en_out},
            32'd0);
        chk("rst_mux", 32'({ctrl_load_mux_out, ctrl_str_mux_out}), 32'd0);
      end else if (cur_v) begin
        chk("start", 32'(memory_stage_start_out), 32'd1);
        chk("tag", 32'(instr_tag_out), 32'(cur.tag));
        chk("rd_addr", 32'(rd_addr_out), 32'(cur.rd));
        chk("rn_addr", 32'(rn_addr_out), 32'(cur.rn_a));
        if (cur.chk_sd) chk("store_data", store_rd_data_out, cur.sd);
        chk("rn_data", rn_data_out, cur.rn_data);
        chk("mem_addr", mem_addr_out, cur.addr);
        chk("swp", 32'(swp_ctrl_out), 32'(cur.swp));
        chk("load_mux", 32'(ctrl_load_mux_out), 32'(cur.lmux));
        chk("str_mux", 32'(ctrl_str_mux_out), 32'(cur.smux));
        chk("w_en", 32'(w_en_out), 32'(cur.wen));
        chk("confirmed", 32'(instr_confirmed_out), 32'(cur.conf));
        chk("lsm_en", 32'(load_store_multiple_en_out), 32'(cur.lsm));
      end else begin
        chk("idle_start", 32'(memory_stage_start_out), 32'd0);
      end
      exp_ready = rel && (q.size() == 0) && !stall_in;
      chk("ready", 32'(issue_ready_out), 32'(exp_ready));
      if (!reset_in) begin
        q.delete(); cur_v = 1'b0; in_rst = 1'b1; rel = 1'b0;
      end else begin
        rel = 1'b1;
        if (!stall_in) begin
          if (issue_valid_in && exp_ready)
            for (int k = 0; k < nbeats(ins); k++) q.push_back(nth_beat(ins, k));
          in_rst = 1'b0;
          if (q.size() > 0) begin cur = q.pop_front(); cur_v = 1'b1; end
          else cur_v = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_stall) stall_in = ($urandom_range(0, 3) == 0);
  endtask

  // Present an instruction and hold it until accepted; returns just after the accepting edge.
  task automatic issue(input instr_t x);
    bit acc;
    acc = 1'b0;
    ins = x;
    issue_valid_in = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = issue_ready_out;
      tick();
    end
    if (!acc) begin
      failures++;
      $display("FAIL issue_timeout: got ready=0 expected accept within 200 cycles");
    end
    issue_valid_in = 1'b0;
  endtask

  function automatic instr_t mk(input logic [2:0] op, input logic [2:0] size, input logic [31:0] rn,
                                input logic [11:0] off, input logic p, input logic u, input logic w,
                                input logic [15:0] list, input logic [31:0] rd_data);
    instr_t x;
    x = '0;
    x.tag = 4'hA; x.rd = 4'd2; x.rn_a = 4'd5;
    x.op = op; x.size = size; x.rn_data = rn; x.off = off;
    x.p = p; x.u = u; x.w = w; x.list = list; x.rd_data = rd_data;
    return x;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    x.tag = 4'($urandom); x.rd = 4'($urandom); x.rn_a = 4'($urandom);
    x.rd_data = $urandom;
    x.rn_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
    x.off = 12'($urandom);
    x.op = 3'($urandom_range(0, 4));
    x.size = 3'($urandom_range(0, 4));
    x.p = 1'($urandom); x.u = 1'($urandom); x.w = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       x.list = '0;
      1:       x.list = 16'd1 << $urandom_range(0, 15);
      default: x.list = 16'($urandom);
    endcase
    return x;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    repeat (3) tick();
    reset_in = 1'b1;
    tick();
    chk("ready_after_reset", 32'(issue_ready_out), 32'd1);

    // STR byte, pre-indexed up
    issue(mk(3'd1, 3'd1, 32'h100, 12'd3, 1'b1, 1'b1, 1'b0, 16'h0, 32'h12345678));
    chk("strb_addr", mem_addr_out, 32'h103);
    chk("strb_wen", 32'(w_en_out), 32'b1000);
    chk("strb_smux", 32'(ctrl_str_mux_out), 32'd1);
    chk("strb_conf", 32'(instr_confirmed_out), 32'd1);

    // LDR signed half, post-indexed down with writeback
    issue(mk(3'd0, 3'd4, 32'h200, 12'd8, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0));
    chk("ldrsh_addr", mem_addr_out, 32'h200);
    chk("ldrsh_rn_data", rn_data_out, 32'h1F8);
    chk("ldrsh_lmux", 32'(ctrl_load_mux_out), 32'd4);
    chk("ldrsh_wen", 32'(w_en_out), 32'd0);

    // STMDB with writeback
    issue(mk(3'd3, 3'd0, 32'h1000, 12'd0, 1'b1, 1'b0, 1'b1, 16'h000B, 32'hCAFE0001));
    chk("stmdb_b1", {mem_addr_out[27:0], rd_addr_out}, {28'hFF4, 4'd0});
    chk("stmdb_b1_conf", 32'(instr_confirmed_out), 32'd0);
    tick();
    chk("stmdb_b2", {mem_addr_out[27:0], rd_addr_out}, {28'hFF8, 4'd1});
    tick();
    chk("stmdb_b3", {mem_addr_out[27:0], rd_addr_out}, {28'hFFC, 4'd3});
    chk("stmdb_rn_data", rn_data_out, 32'hFF4);
    chk("stmdb_b3_conf", 32'(instr_confirmed_out), 32'd1);

    // LDMIA with two stalled cycles on beat 1
    issue(mk(3'd2, 3'd0, 32'h40, 12'd0, 1'b0, 1'b1, 1'b0, 16'h8001, 32'h0));
    stall_in = 1'b1;
    tick();
    chk("ldmia_held", mem_addr_out, 32'h40);
    tick();
    stall_in = 1'b0;
    chk("ldmia_held2", {mem_addr_out[27:0], rd_addr_out}, {28'h40, 4'd0});
    tick();
    chk("ldmia_b2", {mem_addr_out[27:0], rd_addr_out}, {28'h44, 4'd15});

    // SWP
    issue(mk(3'd4, 3'd0, 32'h80, 12'd0, 1'b0, 1'b0, 1'b1, 16'h0, 32'hDEADBEEF));
    chk("swp_b1", {mem_addr_out[27:0], w_en_out}, {28'h80, 4'b0000});
    chk("swp_b1_flags", 32'({swp_ctrl_out, instr_confirmed_out}), 32'b10);
    tick();
    chk("swp_b2", {mem_addr_out[27:0], w_en_out}, {28'h80, 4'b1111});
    chk("swp_b2_data", store_rd_data_out, 32'hDEADBEEF);
    chk("swp_b2_flags", 32'({swp_ctrl_out, instr_confirmed_out}), 32'b11);

    // Reset after beat 2 of a five-register LDM, then an empty-list LDM
    issue(mk(3'd2, 3'd0, 32'h300, 12'd0, 1'b0, 1'b1, 1'b0, 16'h00F1, 32'h0));
    tick();
    chk("ldm5_b2", {mem_addr_out[27:0], rd_addr_out}, {28'h304, 4'd4});
    reset_in = 1'b0;
    tick();
    chk("midreset_start", 32'(memory_stage_start_out), 32'd0);
    chk("midreset_addr", mem_addr_out, 32'd0);
    tick();
    reset_in = 1'b1;
    tick();
    chk("ready_after_midreset", 32'(issue_ready_out), 32'd1);
    issue(mk(3'd2, 3'd0, 32'h500, 12'd0, 1'b1, 1'b1, 1'b1, 16'h0000, 32'h0));
    chk("empty_list_start", 32'(memory_stage_start_out), 32'd0);
    chk("empty_list_ready", 32'(issue_ready_out), 32'd1);

    // Randomized traffic with random stalls and gaps
    rand_stall = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      issue(rand_instr());
    end
    rand_stall = 1'b0;
    stall_in = 1'b0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
